llc_lookup_pipe: RTL and testbench
==================================

Name: llc_lookup_pipe

Overview:
Parametrised, handshaked LLC set-lookup stage for the Spandex LLC. It takes one set's tag, state, owner and line buffers plus a request tag. One cycle later it returns the hit way, the lowest empty way, a replacement victim from an internal round-robin eviction pointer, the owned-word mask, and the per-word owner cache IDs extracted from the hit line. It sits between the LLC set-read stage and the LLC request FSM, and replaces the unhandshaked lookup block.

Parameters:
WAYS, 16, associativity; power of two, at least 2; WAY_W = log2(WAYS)
TAG_W, 20, tag width
STATE_W, 3, per-way state width
INV_STATE, 0, state encoding meaning invalid (LLC_I)
WORDS, 4, words per line
WORD_W, 32, bits per word
CACHE_ID_W, 4, owner cache-ID width; must be at most WORD_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  lookup request valid
req_ready  out  1  stage can accept a request
req_mode  in  2  0=LOOKUP, 1=VICTIM, 2=VICTIM_NOADV, 3=reserved
req_tag  in  TAG_W  tag of incoming address
tags_flat  in  WAYS*TAG_W  way i occupies bits [i*TAG_W +: TAG_W]
states_flat  in  WAYS*STATE_W  per-way state
owners_flat  in  WAYS*WORDS  per-way owned-word mask
lines_flat  in  WAYS*WORDS*WORD_W  per-way line data
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_tag_hit  out  1  tag hit in a non-invalid way
rsp_way_hit  out  WAY_W  hit way
rsp_multi_hit  out  1  more than one way hit (protocol error)
rsp_empty_found  out  1  at least one invalid way exists
rsp_empty_way  out  WAY_W  lowest-index invalid way
rsp_victim_way  out  WAY_W  way selected for allocation
rsp_victim_evict  out  1  victim holds valid data and must be evicted
rsp_word_mask_owned  out  WORDS  owned words of the hit line
rsp_owner_ids  out  WORDS*CACHE_ID_W  word w owner ID at [w*CACHE_ID_W +: CACHE_ID_W]
evict_ptr  out  WAY_W  current round-robin eviction pointer

Behaviour:
- Reset (rst=1 at a clk edge): rsp_valid=0 and every rsp_* output=0; evict_ptr=0. Reset overrides any acceptance or response in the same cycle, and an in-flight result is dropped.
- req_ready = !rsp_valid || rsp_ready (combinational, one-entry output register). A request is accepted when req_valid && req_ready.
- Latency: a request accepted at edge N has its result presented from edge N+1. It holds stable while rsp_valid && !rsp_ready.
- rsp_valid: set on acceptance; cleared when rsp_ready is high and no new request is accepted. Back-to-back acceptance with rsp_ready=1 gives a result every cycle.
- Hit: way i hits when tag(i)==req_tag and state(i)!=INV_STATE.
  - rsp_tag_hit = OR of all hits; rsp_way_hit = lowest hitting index.
  - rsp_multi_hit = 1 when two or more ways hit.
  - With no hit, rsp_way_hit=0.
- Empty: rsp_empty_found = 1 when any state equals INV_STATE; rsp_empty_way = lowest invalid index, else 0.
- Owned mask: rsp_word_mask_owned = owners(way_hit) when there is a hit, else 0.
- Owner IDs: for each word w, rsp_owner_ids[w] = lines(way_hit) word w bits [CACHE_ID_W-1:0] when hit and the mask bit w is 1; otherwise 0.
- Victim, modes 1 and 2, priority order:
  - hit: victim = hit way, evict=0
  - else empty found: victim = empty way, evict=0
  - else: victim = evict_ptr, evict=1
- Eviction pointer:
  - Mode 1 increments evict_ptr modulo WAYS (WAYS-1 wraps to 0) only when evict=1, updated at the acceptance edge.
  - Mode 2 never changes the pointer.
- Mode 0: victim fields = 0 and the pointer is unchanged; hit, empty and owner fields are computed normally.
- Mode 3: result is accepted and presented with every rsp_* field=0; pointer unchanged.
- Stall: request inputs are sampled only at acceptance, so buffer changes during a stall do not affect the held result.

Test Plan:
- Reset, then LOOKUP with way 5 tag=0x1234 valid, req_tag=0x1234, owners(5)=4'b0101, line word0 ID=3, word2 ID=9 -> next cycle rsp_valid=1, tag_hit=1, way_hit=5, mask=0101, owner_ids word0=3, word1=0, word2=9, word3=0.
- All ways valid, no hit, VICTIM three times with evict_ptr=14 (WAYS=16) -> victims 14, 15, 0, each with evict=1; final evict_ptr=1.
- Ways 3 and 7 invalid, no hit, VICTIM -> empty_found=1, empty_way=3, victim=3, evict=0, pointer unchanged; VICTIM_NOADV with no empty way -> victim=evict_ptr and pointer unchanged.
- Ways 2 and 6 both hit -> tag_hit=1, way_hit=2, multi_hit=1.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 and changing buffers -> req_ready=0, result unchanged; raise rsp_ready -> next request accepted the same cycle, new result the cycle after.
- Assert rst while rsp_valid=1 and req_valid=1 -> next cycle rsp_valid=0, all rsp_* outputs=0, evict_ptr=0.

Source files
------------

// File: rtl/llc_lookup_pipe.sv
// llc_lookup_pipe: one-cycle, handshaked LLC set lookup.
//
// Takes one set's tag/state/owner/line buffers plus a request tag. The
// result is registered and presented the cycle after acceptance. It reports:
//   - the hit way, and whether more than one way hit;
//   - the lowest empty way;
//   - a victim way, chosen as hit, then empty, then the round-robin pointer;
//   - the owned-word mask and the per-word owner IDs of the hit line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_mode            0=LOOKUP 1=VICTIM 2=VICTIM_NOADV 3=reserved
//   req_tag             lookup tag
//   tags_flat, states_flat, owners_flat, lines_flat   set buffers (way-major)
//   rsp_valid/rsp_ready response handshake
//   rsp_*               registered lookup result
//   evict_ptr           round-robin eviction pointer
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The request side is ready whenever the single output register
// is empty or is being drained this cycle (req_ready = !rsp_valid ||
// rsp_ready). A held result (rsp_valid && !rsp_ready) stays stable.
module llc_lookup_pipe #(
  parameter int WAYS       = 16,
  parameter int TAG_W      = 20,
  parameter int STATE_W    = 3,
  parameter int INV_STATE  = 0,
  parameter int WORDS      = 4,
  parameter int WORD_W     = 32,
  parameter int CACHE_ID_W = 4,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_mode,
  input  logic [TAG_W-1:0]             req_tag,
  input  logic [WAYS*TAG_W-1:0]        tags_flat,
  input  logic [WAYS*STATE_W-1:0]      states_flat,
  input  logic [WAYS*WORDS-1:0]        owners_flat,
  input  logic [WAYS*WORDS*WORD_W-1:0] lines_flat,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_tag_hit,
  output logic [WAY_W-1:0]             rsp_way_hit,
  output logic                         rsp_multi_hit,
  output logic                         rsp_empty_found,
  output logic [WAY_W-1:0]             rsp_empty_way,
  output logic [WAY_W-1:0]             rsp_victim_way,
  output logic                         rsp_victim_evict,
  output logic [WORDS-1:0]             rsp_word_mask_owned,
  output logic [WORDS*CACHE_ID_W-1:0]  rsp_owner_ids,
  output logic [WAY_W-1:0]             evict_ptr
);

  localparam int LINE_W = WORDS * WORD_W;

  localparam logic [1:0] MODE_LOOKUP       = 2'd0;
  localparam logic [1:0] MODE_VICTIM       = 2'd1;
  localparam logic [1:0] MODE_VICTIM_NOADV = 2'd2;
  localparam logic [1:0] MODE_RSVD         = 2'd3;

  logic                        accept;
  logic [WAYS-1:0]             hit_vec;
  logic [WAYS-1:0]             inv_vec;
  logic                        any_hit;
  logic                        any_inv;
  logic                        multi_hit;
  logic [WAY_W-1:0]            hit_way;
  logic [WAY_W-1:0]            empty_way;
  logic [LINE_W-1:0]           hit_line;
  logic [WORDS-1:0]            hit_owners;
  logic                        unused_line;

  logic                        nxt_tag_hit;
  logic [WAY_W-1:0]            nxt_way_hit;
  logic                        nxt_multi_hit;
  logic                        nxt_empty_found;
  logic [WAY_W-1:0]            nxt_empty_way;
  logic [WAY_W-1:0]            nxt_victim_way;
  logic                        nxt_victim_evict;
  logic [WORDS-1:0]            nxt_mask;
  logic [WORDS*CACHE_ID_W-1:0] nxt_ids;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Per-way match and invalid flags.
  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      inv_vec[i] = (states_flat[i*STATE_W +: STATE_W] == STATE_W'(INV_STATE));
      hit_vec[i] = !inv_vec[i] && (tags_flat[i*TAG_W +: TAG_W] == req_tag);
    end
  end

  assign any_hit   = |hit_vec;
  assign any_inv   = |inv_vec;
  assign multi_hit = ($countones(hit_vec) > 1);

  // Lowest-index priority encoders: the scan runs high to low so the last
  // match written is the lowest index. Both default to 0 when nothing matches.
  always_comb begin
    hit_way   = '0;
    empty_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way   = WAY_W'(i);
      if (inv_vec[i]) empty_way = WAY_W'(i);
    end
  end

  // Select the hit way's line and owner mask.
  always_comb begin
    hit_line   = '0;
    hit_owners = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_way == WAY_W'(i)) begin
        hit_line   = lines_flat[i*LINE_W +: LINE_W];
        hit_owners = owners_flat[i*WORDS +: WORDS];
      end
    end
  end

  // Only the low CACHE_ID_W bits of each word carry an owner ID.
  assign unused_line = ^hit_line;

  always_comb begin
    nxt_tag_hit      = 1'b0;
    nxt_way_hit      = '0;
    nxt_multi_hit    = 1'b0;
    nxt_empty_found  = 1'b0;
    nxt_empty_way    = '0;
    nxt_victim_way   = '0;
    nxt_victim_evict = 1'b0;
    nxt_mask         = '0;
    nxt_ids          = '0;
    // The reserved mode returns an all-zero result.
    if (req_mode != MODE_RSVD) begin
      nxt_tag_hit     = any_hit;
      nxt_way_hit     = hit_way;
      nxt_multi_hit   = multi_hit;
      nxt_empty_found = any_inv;
      nxt_empty_way   = empty_way;
      nxt_mask        = any_hit ? hit_owners : '0;
      for (int w = 0; w < WORDS; w++) begin
        if (nxt_mask[w]) begin
          nxt_ids[w*CACHE_ID_W +: CACHE_ID_W] = hit_line[w*WORD_W +: CACHE_ID_W];
        end
      end
      if ((req_mode == MODE_VICTIM) || (req_mode == MODE_VICTIM_NOADV)) begin
        if (any_hit) begin
          nxt_victim_way = hit_way;
        end else if (any_inv) begin
          nxt_victim_way = empty_way;
        end else begin
          nxt_victim_way   = evict_ptr;
          nxt_victim_evict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid           <= 1'b0;
      rsp_tag_hit         <= 1'b0;
      rsp_way_hit         <= '0;
      rsp_multi_hit       <= 1'b0;
      rsp_empty_found     <= 1'b0;
      rsp_empty_way       <= '0;
      rsp_victim_way      <= '0;
      rsp_victim_evict    <= 1'b0;
      rsp_word_mask_owned <= '0;
      rsp_owner_ids       <= '0;
      evict_ptr           <= '0;
    end else if (accept) begin
      rsp_valid           <= 1'b1;
      rsp_tag_hit         <= nxt_tag_hit;
      rsp_way_hit         <= nxt_way_hit;
      rsp_multi_hit       <= nxt_multi_hit;
      rsp_empty_found     <= nxt_empty_found;
      rsp_empty_way       <= nxt_empty_way;
      rsp_victim_way      <= nxt_victim_way;
      rsp_victim_evict    <= nxt_victim_evict;
      rsp_word_mask_owned <= nxt_mask;
      rsp_owner_ids       <= nxt_ids;
      // WAYS is a power of two, so the natural wrap gives modulo WAYS.
      if ((req_mode == MODE_VICTIM) && nxt_victim_evict) begin
        evict_ptr <= evict_ptr + WAY_W'(1);
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // LOOKUP takes the default path above; the name documents the encoding.
  localparam logic [1:0] MODE_DEFAULT = MODE_LOOKUP;

endmodule

// File: tb/tb_llc_lookup_pipe.sv
module tb_llc_lookup_pipe;

  localparam int WAYS    = 16;
  localparam int TAG_W   = 20;
  localparam int STATE_W = 3;
  localparam int WORDS   = 4;
  localparam int WORD_W  = 32;
  localparam int CID_W   = 4;
  localparam int WAY_W   = 4;
  localparam int RSP_W   = 36;

  typedef struct packed {
    logic             tag_hit;
    logic [WAY_W-1:0] way_hit;
    logic             multi;
    logic             empty_found;
    logic [WAY_W-1:0] empty_way;
    logic [WAY_W-1:0] victim;
    logic             evict;
    logic [WORDS-1:0] mask;
    logic [WORDS*CID_W-1:0] ids;
  } rsp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] hit_mask;
    logic [15:0] inv_mask;
    rsp_t        exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]                   req_mode;
  logic [TAG_W-1:0]             req_tag;
  logic [WAYS*TAG_W-1:0]        tags_flat;
  logic [WAYS*STATE_W-1:0]      states_flat;
  logic [WAYS*WORDS-1:0]        owners_flat;
  logic [WAYS*WORDS*WORD_W-1:0] lines_flat;
  logic                         rsp_tag_hit, rsp_multi_hit, rsp_empty_found, rsp_victim_evict;
  logic [WAY_W-1:0]             rsp_way_hit, rsp_empty_way, rsp_victim_way, evict_ptr;
  logic [WORDS-1:0]             rsp_word_mask_owned;
  logic [WORDS*CID_W-1:0]       rsp_owner_ids;
  logic [RSP_W-1:0]             dut_rsp;

  llc_lookup_pipe dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_tag(req_tag),
    .tags_flat(tags_flat), .states_flat(states_flat), .owners_flat(owners_flat),
    .lines_flat(lines_flat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag_hit(rsp_tag_hit), .rsp_way_hit(rsp_way_hit), .rsp_multi_hit(rsp_multi_hit),
    .rsp_empty_found(rsp_empty_found), .rsp_empty_way(rsp_empty_way),
    .rsp_victim_way(rsp_victim_way), .rsp_victim_evict(rsp_victim_evict),
    .rsp_word_mask_owned(rsp_word_mask_owned), .rsp_owner_ids(rsp_owner_ids),
    .evict_ptr(evict_ptr)
  );

  assign dut_rsp = {rsp_tag_hit, rsp_way_hit, rsp_multi_hit, rsp_empty_found, rsp_empty_way,
                    rsp_victim_way, rsp_victim_evict, rsp_word_mask_owned, rsp_owner_ids};

  // ---------------- set buffers ----------------
  logic [TAG_W-1:0]   tag_a  [WAYS];
  logic [STATE_W-1:0] st_a   [WAYS];
  logic [WORDS-1:0]   own_a  [WAYS];
  logic [WORD_W-1:0]  line_a [WAYS][WORDS];

  always_comb begin
    tags_flat   = '0;
    states_flat = '0;
    owners_flat = '0;
    lines_flat  = '0;
    for (int i = 0; i < WAYS; i++) begin
      tags_flat[i*TAG_W +: TAG_W]       = tag_a[i];
      states_flat[i*STATE_W +: STATE_W] = st_a[i];
      owners_flat[i*WORDS +: WORDS]     = own_a[i];
      for (int w = 0; w < WORDS; w++)
        lines_flat[(i*WORDS + w)*WORD_W +: WORD_W] = line_a[i][w];
    end
  end

  // Ways in hit_mask hold tag; ways in inv_mask are invalid; others hold
  // distinct non-matching tags with assorted valid states.
  function automatic void set_bufs(input logic [15:0] hit_mask, input logic [15:0] inv_mask,
                                   input logic [TAG_W-1:0] tag);
    for (int i = 0; i < WAYS; i++) begin
      tag_a[i] = hit_mask[i] ? tag : TAG_W'(32'h80000 + i);
      st_a[i]  = inv_mask[i] ? '0 : STATE_W'(1 + (i % 7));
      own_a[i] = '0;
      for (int w = 0; w < WORDS; w++) line_a[i][w] = '0;
    end
  endfunction

  function automatic void rand_bufs();
    for (int i = 0; i < WAYS; i++) begin
      tag_a[i] = TAG_W'($urandom_range(0, 7));
      st_a[i]  = ($urandom_range(0, 15) == 0) ? '0 : STATE_W'($urandom_range(1, 7));
      own_a[i] = WORDS'($urandom);
      for (int w = 0; w < WORDS; w++) line_a[i][w] = $urandom;
    end
  endfunction

  // ---------------- reference model ----------------
  logic [WAY_W-1:0] mptr;

  function automatic rsp_t model(input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                                 input logic [WAY_W-1:0] ptr, output logic adv);
    rsp_t r;
    int hits[$];
    int emps[$];
    r   = '0;
    adv = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (st_a[i] == 0) emps.push_back(i);
      else if (tag_a[i] == tag) hits.push_back(i);
    end
    if (mode == 2'd3) return r;
    if (hits.size() > 0) begin
      r.tag_hit = 1'b1;
      r.way_hit = WAY_W'(hits[0]);
      r.multi   = (hits.size() > 1);
      r.mask    = own_a[hits[0]];
      for (int w = 0; w < WORDS; w++)
        if (r.mask[w]) r.ids[w*CID_W +: CID_W] = line_a[hits[0]][w][CID_W-1:0];
    end
    if (emps.size() > 0) begin
      r.empty_found = 1'b1;
      r.empty_way   = WAY_W'(emps[0]);
    end
    if (mode == 2'd1 || mode == 2'd2) begin
      if (hits.size() > 0)      r.victim = WAY_W'(hits[0]);
      else if (emps.size() > 0) r.victim = WAY_W'(emps[0]);
      else begin
        r.victim = ptr;
        r.evict  = 1'b1;
      end
      adv = (mode == 2'd1) && r.evict;
    end
    return r;
  endfunction

  function automatic rsp_t mk_exp(input logic h, input int way, input logic m,
                                  input logic ef, input int ew);
    rsp_t r;
    r             = '0;
    r.tag_hit     = h;
    r.way_hit     = WAY_W'(way);
    r.multi       = m;
    r.empty_found = ef;
    r.empty_way   = WAY_W'(ew);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [RSP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call between negedge and posedge with rsp_ready=1 so acceptance is certain.
  task automatic drive(input logic [1:0] mode, input logic [TAG_W-1:0] tag, output rsp_t e);
    logic adv;
    req_valid = 1'b1;
    req_mode  = mode;
    req_tag   = tag;
    e = model(mode, tag, mptr, adv);
    if (adv) mptr = mptr + 1'b1;
  endtask

  task automatic step(input string name, input rsp_t e);
    @(posedge clk);
    #1;
    check(name, dut_rsp, e);
    check({name, "_valid"}, rsp_valid, 1);
    check({name, "_ptr"}, evict_ptr, mptr);
  endtask

  // ---------------- stimulus ----------------
  vec_t  tbl[7];
  rsp_t  e, e_hold;
  logic  adv;
  logic  exp_ready;
  int    vic_exp[3];

  initial begin
    tbl[0] = '{mode: 2'd0, hit_mask: 16'h0020, inv_mask: 16'h0000, exp: mk_exp(1, 5, 0, 0, 0)};
    tbl[1] = '{mode: 2'd0, hit_mask: 16'h0044, inv_mask: 16'h0000, exp: mk_exp(1, 2, 1, 0, 0)};
    tbl[2] = '{mode: 2'd0, hit_mask: 16'h0000, inv_mask: 16'h0088, exp: mk_exp(0, 0, 0, 1, 3)};
    tbl[3] = '{mode: 2'd0, hit_mask: 16'h8000, inv_mask: 16'h0001, exp: mk_exp(1, 15, 0, 1, 0)};
    tbl[4] = '{mode: 2'd0, hit_mask: 16'h0010, inv_mask: 16'h0010, exp: mk_exp(0, 0, 0, 1, 4)};
    tbl[5] = '{mode: 2'd0, hit_mask: 16'h0000, inv_mask: 16'h0000, exp: mk_exp(0, 0, 0, 0, 0)};
    tbl[6] = '{mode: 2'd3, hit_mask: 16'h0060, inv_mask: 16'h0100, exp: mk_exp(0, 0, 0, 0, 0)};
    vic_exp = '{14, 15, 0};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; req_mode = 2'd0; req_tag = '0;
    set_bufs(16'h0, 16'h0, '0);
    mptr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", rsp_valid, 0);
    check("reset_rsp", dut_rsp, 0);
    check("reset_ptr", evict_ptr, 0);
    check("reset_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Table of single LOOKUP / reserved-mode vectors.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set_bufs(tbl[k].hit_mask, tbl[k].inv_mask, 20'h01234);
      drive(tbl[k].mode, 20'h01234, e);
      step($sformatf("tbl%0d", k), tbl[k].exp);
    end

    // Owned-word mask and owner IDs from the hit line.
    @(negedge clk);
    set_bufs(16'h0020, 16'h0, 20'h01234);
    own_a[5]     = 4'b0101;
    line_a[5][0] = 32'hABCDE003;
    line_a[5][1] = 32'h00000005;
    line_a[5][2] = 32'h12345679;
    line_a[5][3] = 32'hFFFFFFF7;
    drive(2'd0, 20'h01234, e);
    e = mk_exp(1, 5, 0, 0, 0);
    e.mask = 4'b0101;
    e.ids  = 16'h0903;
    step("owner", e);

    // Victim from an empty way does not advance the pointer.
    @(negedge clk);
    set_bufs(16'h0, 16'h0088, 20'h01234);
    drive(2'd1, 20'h01234, e);
    step("vic_empty", e);
    check("vic_empty_way", rsp_victim_way, 3);
    check("vic_empty_evict", rsp_victim_evict, 0);

    // VICTIM_NOADV with a full set: pointer victim, pointer held.
    @(negedge clk);
    set_bufs(16'h0, 16'h0, 20'h01234);
    drive(2'd2, 20'h01234, e);
    step("noadv", e);
    check("noadv_way", rsp_victim_way, 0);
    check("noadv_evict", rsp_victim_evict, 1);

    // Walk the pointer to 14, then watch it wrap.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      set_bufs(16'h0, 16'h0, 20'h01234);
      drive(2'd1, 20'h01234, e);
      step("walk", e);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      set_bufs(16'h0, 16'h0, 20'h01234);
      drive(2'd1, 20'h01234, e);
      step($sformatf("wrap%0d", j), e);
      check($sformatf("wrap%0d_way", j), rsp_victim_way, vic_exp[j]);
      check($sformatf("wrap%0d_evict", j), rsp_victim_evict, 1);
    end
    check("wrap_ptr", evict_ptr, 1);

    // Stall: held result and no acceptance while buffers churn.
    @(negedge clk);
    set_bufs(16'h0100, 16'h0, 20'h01234);
    drive(2'd0, 20'h01234, e_hold);
    step("stall_pre", e_hold);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      set_bufs(16'h0, 16'h0, 20'h01234);
      tag_a[s]  = 20'h01234;
      req_valid = 1'b1;
      req_mode  = 2'd1;
      #1;
      check("stall_ready", req_ready, 0);
      @(posedge clk);
      #1;
      check("stall_hold", dut_rsp, e_hold);
      check("stall_valid", rsp_valid, 1);
      check("stall_ptr", evict_ptr, mptr);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    set_bufs(16'h0, 16'h0, 20'h01234);
    #1;
    check("unstall_ready", req_ready, 1);
    drive(2'd1, 20'h01234, e);
    step("unstall", e);

    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", rsp_valid, 0);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rand_bufs();
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_mode  = 2'($urandom_range(0, 3));
      req_tag   = TAG_W'($urandom_range(0, 7));
      #1;
      exp_ready = (exp_q.size() == 0) || rsp_ready;
      check("rnd_ready", req_ready, exp_ready);
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && exp_ready) begin
        e = model(req_mode, req_tag, mptr, adv);
        if (adv) mptr = mptr + 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check("rnd_valid", rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("rnd_rsp", dut_rsp, exp_q[0]);
      check("rnd_ptr", evict_ptr, mptr);
    end

    // Reset with a result in flight and a request pending.
    @(negedge clk);
    rsp_ready = 1'b1;
    set_bufs(16'h0, 16'h0, 20'h01234);
    drive(2'd1, 20'h01234, e);
    exp_q.delete();
    step("pre_rst", e);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_mode  = 2'd1;
    @(posedge clk);
    #1;
    mptr = '0;
    check("rst_valid", rsp_valid, 0);
    check("rst_rsp", dut_rsp, 0);
    check("rst_ptr", evict_ptr, mptr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
